// File: rtl/pacman_motion_ctrl.sv
// Pac-Man per-frame motion scheduler: buffers the wanted direction, proposes at
// most one one-pixel move per frame to the external collision checker over a
// req/ack handshake, commits clear moves, and sequences title and win screens.
module pacman_motion_ctrl #(
    parameter int START_X       = 310,
    parameter int START_Y       = 230,
    parameter int X_MAX         = 618,
    parameter int Y_MAX         = 458,
    parameter int TITLE_FRAMES  = 2,
    parameter int CHECK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTNC,
    output logic       check_req,
    output logic [9:0] check_x,
    output logic [8:0] check_y,
    input  logic       check_ack,
    input  logic       check_blocked,
    input  logic       level_done,
    output logic [9:0] pacman_x,
    output logic [8:0] pacman_y,
    output logic [1:0] facing,
    output logic       show_title,
    output logic       won
);

    localparam int WCW = $clog2(CHECK_TIMEOUT + 1);
    localparam int TCW = $clog2(TITLE_FRAMES + 1);
    localparam logic [9:0]     START_X_C = 10'(START_X);
    localparam logic [8:0]     START_Y_C = 9'(START_Y);
    localparam logic [9:0]     X_MAX_C   = 10'(X_MAX);
    localparam logic [8:0]     Y_MAX_C   = 9'(Y_MAX);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(CHECK_TIMEOUT - 1);
    localparam logic [TCW-1:0] TITLE_LD  = TCW'(TITLE_FRAMES);
    localparam logic [TCW-1:0] TITLE_ONE = TCW'(1);

    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_L = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    typedef enum logic [2:0] {
        ST_TITLE   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CHK_DES = 3'd2,
        ST_CHK_CUR = 3'd3,
        ST_WON     = 3'd4
    } state_t;

    state_t         state_r;
    logic           req_r;
    logic [9:0]     cx_r;
    logic [8:0]     cy_r;
    logic [WCW-1:0] wait_cnt_r;
    logic           blk_now_r;
    logic           launch_r;
    logic [TCW-1:0] title_cnt_r;
    logic [1:0]     des_dir_r;
    logic           des_valid_r;
    logic [1:0]     cur_dir_r;
    logic           cur_valid_r;
    logic [9:0]     px_r;
    logic [8:0]     py_r;
    logic [1:0]     facing_r;
    logic           show_title_r;
    logic           won_r;

    // Candidate one pixel away in dir; bit 19 flags "already at the edge"
    // (position unchanged in that case).
    function automatic logic [19:0] cand_calc(input logic [1:0] dir,
                                              input logic [9:0] x,
                                              input logic [8:0] y);
        logic       lim;
        logic [9:0] nx;
        logic [8:0] ny;
        lim = 1'b0;
        nx  = x;
        ny  = y;
        case (dir)
            DIR_R: if (x >= X_MAX_C) lim = 1'b1; else nx = x + 10'd1;
            DIR_L: if (x == 10'd0)   lim = 1'b1; else nx = x - 10'd1;
            DIR_U: if (y == 9'd0)    lim = 1'b1; else ny = y - 9'd1;
            DIR_D: if (y >= Y_MAX_C) lim = 1'b1; else ny = y + 9'd1;
            default: lim = 1'b1;
        endcase
        return {lim, nx, ny};
    endfunction

    logic        btn_any_s;
    logic [1:0]  btn_dir_s;
    logic [19:0] launch_cand_s;
    logic        do_launch_s;
    logic        ack_hit_s;
    logic        timeout_s;
    logic        res_valid_s;
    logic        res_blocked_s;
    logic        active_s;

    // Button priority encoder, U > D > L > R.
    always_comb begin
        btn_any_s = 1'b1;
        btn_dir_s = DIR_R;
        if (BTNU)      btn_dir_s = DIR_U;
        else if (BTND) btn_dir_s = DIR_D;
        else if (BTNL) btn_dir_s = DIR_L;
        else if (BTNR) btn_dir_s = DIR_R;
        else           btn_any_s = 1'b0;
    end

    // Launch decision, candidate selection and checker result decoding.
    always_comb begin
        active_s = (state_r == ST_IDLE) || (state_r == ST_CHK_DES) ||
                   (state_r == ST_CHK_CUR);
        if ((state_r == ST_IDLE) && des_valid_r)
            launch_cand_s = cand_calc(des_dir_r, px_r, py_r);
        else
            launch_cand_s = cand_calc(cur_dir_r, px_r, py_r);
        if (level_done)
            do_launch_s = 1'b0;
        else if (state_r == ST_IDLE)
            do_launch_s = frame_tick && (des_valid_r || cur_valid_r);
        else if (state_r == ST_CHK_CUR)
            do_launch_s = launch_r;
        else
            do_launch_s = 1'b0;
        ack_hit_s     = req_r && check_ack;
        timeout_s     = req_r && !check_ack && (wait_cnt_r == WAIT_LAST);
        res_valid_s   = ack_hit_s || timeout_s || blk_now_r;
        res_blocked_s = blk_now_r || timeout_s || (ack_hit_s && check_blocked);
    end

    // Main state machine with all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_TITLE;
            req_r        <= 1'b0;
            cx_r         <= START_X_C;
            cy_r         <= START_Y_C;
            wait_cnt_r   <= '0;
            blk_now_r    <= 1'b0;
            launch_r     <= 1'b0;
            title_cnt_r  <= TITLE_LD;
            des_dir_r    <= DIR_R;
            des_valid_r  <= 1'b0;
            cur_dir_r    <= DIR_R;
            cur_valid_r  <= 1'b0;
            px_r         <= START_X_C;
            py_r         <= START_Y_C;
            facing_r     <= DIR_R;
            show_title_r <= 1'b1;
            won_r        <= 1'b0;
        end else begin
            if (req_r && !check_ack && !timeout_s) begin
                wait_cnt_r <= wait_cnt_r + WCW'(1);
            end
            case (state_r)
                ST_TITLE: begin
                    if (frame_tick && BTNC) begin
                        title_cnt_r <= title_cnt_r - TCW'(1);
                        if (title_cnt_r <= TITLE_ONE) begin
                            state_r      <= ST_IDLE;
                            show_title_r <= 1'b0;
                        end
                    end
                end
                ST_IDLE, ST_CHK_DES, ST_CHK_CUR: begin
                    if (level_done) begin
                        // Abandon any outstanding check; nothing commits.
                        state_r   <= ST_WON;
                        won_r     <= 1'b1;
                        req_r     <= 1'b0;
                        blk_now_r <= 1'b0;
                        launch_r  <= 1'b0;
                    end else if (state_r == ST_IDLE) begin
                        if (frame_tick && des_valid_r)      state_r <= ST_CHK_DES;
                        else if (frame_tick && cur_valid_r) state_r <= ST_CHK_CUR;
                    end else if (state_r == ST_CHK_CUR && launch_r) begin
                        launch_r <= 1'b0;
                    end else if (res_valid_s) begin
                        req_r     <= 1'b0;
                        blk_now_r <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (!res_blocked_s) begin
                            px_r <= cx_r;
                            py_r <= cy_r;
                        end
                        if (state_r == ST_CHK_DES) begin
                            if (!res_blocked_s) begin
                                cur_dir_r   <= des_dir_r;
                                cur_valid_r <= 1'b1;
                                des_valid_r <= 1'b0;
                                facing_r    <= des_dir_r;
                            end else if (cur_valid_r && (cur_dir_r != des_dir_r)) begin
                                // Fall back to the current direction next cycle.
                                state_r  <= ST_CHK_CUR;
                                launch_r <= 1'b1;
                            end
                        end else if (res_blocked_s) begin
                            cur_valid_r <= 1'b0;
                        end
                    end
                end
                ST_WON: begin
                    if (frame_tick && BTNC) begin
                        state_r      <= ST_TITLE;
                        px_r         <= START_X_C;
                        py_r         <= START_Y_C;
                        cx_r         <= START_X_C;
                        cy_r         <= START_Y_C;
                        des_valid_r  <= 1'b0;
                        cur_valid_r  <= 1'b0;
                        facing_r     <= DIR_R;
                        title_cnt_r  <= TITLE_LD;
                        show_title_r <= 1'b1;
                        won_r        <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_TITLE;
                end
            endcase
            if (do_launch_s) begin
                cx_r <= launch_cand_s[18:9];
                cy_r <= launch_cand_s[8:0];
                if (launch_cand_s[19]) begin
                    blk_now_r <= 1'b1;
                end else begin
                    req_r      <= 1'b1;
                    wait_cnt_r <= '0;
                end
            end
            // A press in the commit cycle overrides the clear above.
            if (active_s && btn_any_s) begin
                des_dir_r   <= btn_dir_s;
                des_valid_r <= 1'b1;
            end
        end
    end

    assign check_req  = req_r;
    assign check_x    = cx_r;
    assign check_y    = cy_r;
    assign pacman_x   = px_r;
    assign pacman_y   = py_r;
    assign facing     = facing_r;
    assign show_title = show_title_r;
    assign won        = won_r;

endmodule
